// File: rtl/pc_redirect_ctrl.sv
// Fetch-side PC generator with branch/jump redirect, flush and misaligned-target trap.
// Control is a RUN/FLUSH/HALT machine; a taken transfer in RUN either redirects or halts.
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [31:0] fetch_pc,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic        ex_is_jal,
  input  logic        ex_is_jalr,
  input  logic        br_cond,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [31:0] ex_rs1,
  output logic [31:0] link_addr,
  output logic        redirect,
  output logic        flush,
  output logic        misalign_trap,
  output logic [31:0] trap_pc
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_redirect;
  logic        r_trap;
  logic        r_trap_flush;
  logic [31:0] r_trap_pc;
  logic [3:0]  r_cnt;

  state_t      w_state_next;
  logic [31:0] w_pc_next;
  logic        w_redirect_next;
  logic        w_trap_next;
  logic        w_trap_flush_next;
  logic [31:0] w_trap_pc_next;
  logic [3:0]  w_cnt_next;

  logic        w_taken;
  logic [31:0] w_jalr_sum;
  logic [31:0] w_target;
  logic        w_aligned;
  logic        w_fetch_valid;

  // Shadow instructions behind a redirect, and anything after a trap, are ignored.
  assign w_taken = (r_state == RUN) & ex_valid &
                   (ex_is_jalr | ex_is_jal | (ex_is_branch & br_cond));

  assign w_jalr_sum    = ex_rs1 + ex_imm;
  assign w_target      = ex_is_jalr ? (w_jalr_sum & ~32'h1) : (ex_pc + ex_imm);
  assign w_aligned     = (w_target[1:0] == 2'b00);
  assign w_fetch_valid = (r_state != HALT) & ~stall;

  always_comb begin
    w_state_next      = r_state;
    w_pc_next         = r_pc;
    w_redirect_next   = 1'b0;
    w_trap_next       = r_trap;
    w_trap_flush_next = 1'b0;
    w_trap_pc_next    = r_trap_pc;
    w_cnt_next        = r_cnt;

    if (w_taken && w_aligned) begin
      w_pc_next       = w_target;
    end else if (r_state == HALT || stall) begin
      w_pc_next       = r_pc;
    end else if (w_fetch_valid && fetch_ready) begin
      w_pc_next       = r_pc + 32'd4;
    end

    case (r_state)
      RUN: begin
        if (w_taken) begin
          if (w_aligned) begin
            w_redirect_next = 1'b1;
            w_state_next    = FLUSH;
            w_cnt_next      = FLUSH_LOAD;
          end else begin
            w_trap_next       = 1'b1;
            w_trap_flush_next = 1'b1;
            w_trap_pc_next    = ex_pc;
            w_state_next      = HALT;
          end
        end
      end
      FLUSH: begin
        if (r_cnt == 4'd0) begin
          w_state_next = RUN;
        end else begin
          w_cnt_next   = r_cnt - 4'd1;
        end
      end
      HALT: begin
        w_state_next = HALT;
      end
      default: begin
        w_state_next = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= RUN;
      r_pc         <= RESET_PC;
      r_redirect   <= 1'b0;
      r_trap       <= 1'b0;
      r_trap_flush <= 1'b0;
      r_trap_pc    <= 32'h0;
      r_cnt        <= 4'd0;
    end else begin
      r_state      <= w_state_next;
      r_pc         <= w_pc_next;
      r_redirect   <= w_redirect_next;
      r_trap       <= w_trap_next;
      r_trap_flush <= w_trap_flush_next;
      r_trap_pc    <= w_trap_pc_next;
      r_cnt        <= w_cnt_next;
    end
  end

  assign fetch_valid   = w_fetch_valid;
  assign fetch_pc      = r_pc;
  assign link_addr     = ex_pc + 32'd4;
  assign redirect      = r_redirect;
  assign flush         = (r_state == FLUSH) | r_trap_flush;
  assign misalign_trap = r_trap;
  assign trap_pc       = r_trap_pc;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl: sequential fetch, back-pressure, redirects,
// misaligned-target trap and address wrap, with hand-computed expectations.
module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_pc;
  logic        ex_valid;
  logic        ex_is_branch;
  logic        ex_is_jal;
  logic        ex_is_jalr;
  logic        br_cond;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] ex_rs1;
  logic [31:0] link_addr;
  logic        redirect;
  logic        flush;
  logic        misalign_trap;
  logic [31:0] trap_pc;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  pc_redirect_ctrl #(
    .RESET_PC    (32'h0000_0000),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .fetch_valid  (fetch_valid),
    .fetch_ready  (fetch_ready),
    .fetch_pc     (fetch_pc),
    .ex_valid     (ex_valid),
    .ex_is_branch (ex_is_branch),
    .ex_is_jal    (ex_is_jal),
    .ex_is_jalr   (ex_is_jalr),
    .br_cond      (br_cond),
    .ex_pc        (ex_pc),
    .ex_imm       (ex_imm),
    .ex_rs1       (ex_rs1),
    .link_addr    (link_addr),
    .redirect     (redirect),
    .flush        (flush),
    .misalign_trap(misalign_trap),
    .trap_pc      (trap_pc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_clear();
    ex_valid     = 1'b0;
    ex_is_branch = 1'b0;
    ex_is_jal    = 1'b0;
    ex_is_jalr   = 1'b0;
    br_cond      = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; fetch_ready = 1'b1;
    ex_pc = '0; ex_imm = '0; ex_rs1 = '0;
    ex_clear();
    step(); step();
    // T1 reset state and sequential fetch
    chk("rst_pc", fetch_pc, 32'h0);
    chk("rst_redirect", {31'b0, redirect}, 32'h0);
    chk("rst_flush", {31'b0, flush}, 32'h0);
    chk("rst_trap", {31'b0, misalign_trap}, 32'h0);
    chk("rst_trap_pc", trap_pc, 32'h0);
    chk("rst_fvalid", {31'b0, fetch_valid}, 32'h1);
    rst = 1'b0;
    step(); chk("seq_pc4", fetch_pc, 32'h4);
    step(); chk("seq_pc8", fetch_pc, 32'h8);
    chk("seq_redirect", {31'b0, redirect}, 32'h0);

    // T2 imem back-pressure and stall
    fetch_ready = 1'b0;
    step(); chk("nready_hold1", fetch_pc, 32'h8);
    step(); chk("nready_hold2", fetch_pc, 32'h8);
    chk("nready_fvalid", {31'b0, fetch_valid}, 32'h1);
    fetch_ready = 1'b1; stall = 1'b1; #1;
    chk("stall_fvalid", {31'b0, fetch_valid}, 32'h0);
    step(); chk("stall_hold", fetch_pc, 32'h8);
    stall = 1'b0;

    // T3 taken BEQ, then a JAL in the flush shadow that must be ignored
    ex_valid = 1'b1; ex_is_branch = 1'b1; br_cond = 1'b1;
    ex_pc = 32'h100; ex_imm = 32'h40; #1;
    chk("beq_link", link_addr, 32'h104);
    step();
    chk("beq_pc", fetch_pc, 32'h140);
    chk("beq_redirect", {31'b0, redirect}, 32'h1);
    chk("beq_flush1", {31'b0, flush}, 32'h1);
    ex_clear(); ex_valid = 1'b1; ex_is_jal = 1'b1; ex_pc = 32'h300; ex_imm = 32'h10;
    step();
    chk("shadow_pc", fetch_pc, 32'h144);
    chk("shadow_redirect", {31'b0, redirect}, 32'h0);
    chk("beq_flush2", {31'b0, flush}, 32'h1);
    step();
    chk("shadow2_pc", fetch_pc, 32'h148);
    chk("beq_flush_end", {31'b0, flush}, 32'h0);
    chk("shadow2_redirect", {31'b0, redirect}, 32'h0);
    ex_clear();

    // T4 JALR, bit 0 of the sum cleared
    ex_valid = 1'b1; ex_is_jalr = 1'b1; ex_rs1 = 32'h2003; ex_imm = 32'h1; ex_pc = 32'h400; #1;
    chk("jalr_link", link_addr, 32'h404);
    step();
    chk("jalr_pc", fetch_pc, 32'h2004);
    chk("jalr_redirect", {31'b0, redirect}, 32'h1);
    ex_clear();
    step(); chk("jalr_flush_pc", fetch_pc, 32'h2008);
    step(); chk("jalr_run_pc", fetch_pc, 32'h200C);
    // JALR+JAL both set under stall: JALR wins and redirect overrides stall
    stall = 1'b1;
    ex_valid = 1'b1; ex_is_jalr = 1'b1; ex_is_jal = 1'b1;
    ex_rs1 = 32'h3000; ex_imm = 32'h10; ex_pc = 32'h500;
    step();
    chk("stall_jalr_pc", fetch_pc, 32'h3010);
    chk("stall_jalr_redirect", {31'b0, redirect}, 32'h1);
    ex_clear();
    step();
    chk("stall_flush_hold", fetch_pc, 32'h3010);
    chk("stall_flush", {31'b0, flush}, 32'h1);
    step();
    chk("stall_run_flush", {31'b0, flush}, 32'h0);
    stall = 1'b0;

    // T5 misaligned JAL target -> trap and HALT
    ex_valid = 1'b1; ex_is_jal = 1'b1; ex_pc = 32'h200; ex_imm = 32'h6;
    step();
    chk("trap_set", {31'b0, misalign_trap}, 32'h1);
    chk("trap_pc", trap_pc, 32'h200);
    chk("trap_flush", {31'b0, flush}, 32'h1);
    chk("trap_no_redirect", {31'b0, redirect}, 32'h0);
    chk("trap_fvalid", {31'b0, fetch_valid}, 32'h0);
    chk("trap_pc_adv", fetch_pc, 32'h3014);
    ex_clear();
    ex_valid = 1'b1; ex_is_branch = 1'b1; br_cond = 1'b1; ex_pc = 32'h700; ex_imm = 32'h20;
    step();
    chk("halt_pc_hold", fetch_pc, 32'h3014);
    chk("halt_flush_off", {31'b0, flush}, 32'h0);
    chk("halt_no_redirect", {31'b0, redirect}, 32'h0);
    chk("halt_sticky", {31'b0, misalign_trap}, 32'h1);
    ex_clear();
    rst = 1'b1;
    step();
    chk("rst2_pc", fetch_pc, 32'h0);
    chk("rst2_trap", {31'b0, misalign_trap}, 32'h0);
    chk("rst2_trap_pc", trap_pc, 32'h0);
    chk("rst2_fvalid", {31'b0, fetch_valid}, 32'h1);
    rst = 1'b0;

    // T6 address wrap and not-taken branch
    ex_pc = 32'hFFFF_FFFC; #1;
    chk("link_wrap", link_addr, 32'h0);
    ex_valid = 1'b1; ex_is_jal = 1'b1; ex_pc = 32'hFFFF_FFF0; ex_imm = 32'hC;
    step();
    chk("wrap_target", fetch_pc, 32'hFFFF_FFFC);
    ex_clear();
    step(); chk("wrap_pc", fetch_pc, 32'h0);
    step(); chk("wrap_pc4", fetch_pc, 32'h4);
    ex_valid = 1'b1; ex_is_branch = 1'b1; br_cond = 1'b0; ex_pc = 32'h100; ex_imm = 32'h40;
    step();
    chk("nt_pc", fetch_pc, 32'h8);
    chk("nt_redirect", {31'b0, redirect}, 32'h0);
    chk("nt_flush", {31'b0, flush}, 32'h0);
    ex_clear();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
